// File: rtl/fmlarb_rr.sv
// rtl/fmlarb_rr.sv - N-master round-robin FML arbiter with burst-held write data mux
module fmlarb_rr #(
    parameter int fml_depth = 25,
    parameter int dw        = 16,
    parameter int nm        = 4,
    parameter int burst_len = 4,
    parameter int prio0     = 1,
    localparam int mw       = $clog2(nm),
    localparam int bw       = $clog2(burst_len)
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [nm*fml_depth-1:0] m_adr,
    input  logic [nm-1:0]           m_stb,
    input  logic [nm-1:0]           m_we,
    input  logic [nm*dw/8-1:0]      m_sel,
    input  logic [nm*dw-1:0]        m_di,
    output logic [nm-1:0]           m_ack,
    output logic [dw-1:0]           m_do,
    output logic [fml_depth-1:0]    s_adr,
    output logic                    s_stb,
    output logic                    s_we,
    input  logic                    s_ack,
    output logic [dw/8-1:0]         s_sel,
    input  logic [dw-1:0]           s_di,
    output logic [dw-1:0]           s_do,
    output logic [mw-1:0]           grant,
    output logic                    wburst
);

    logic [mw-1:0]        master;
    logic [mw-1:0]        next_master;
    logic [mw-1:0]        wmaster;
    logic [mw-1:0]        dsel;
    logic [bw-1:0]        cnt;
    logic                 arb_point;
    logic                 found;
    logic                 write_start;
    int                   idx;

    logic [fml_depth-1:0] adr_a [nm];
    logic [dw/8-1:0]      sel_a [nm];
    logic [dw-1:0]        di_a  [nm];

    for (genvar i = 0; i < nm; i++) begin : g_slice
        assign adr_a[i] = m_adr[i*fml_depth +: fml_depth];
        assign sel_a[i] = m_sel[i*(dw/8) +: dw/8];
        assign di_a[i]  = m_di[i*dw +: dw];
    end

    assign s_adr  = adr_a[master];
    assign s_stb  = m_stb[master];
    assign s_we   = m_we[master];
    assign m_do   = s_di;
    assign grant  = master;
    assign wburst = (cnt != '0);

    // Trailing beats come from the burst owner; the ack beat and idle cycles from the command master.
    assign dsel  = (wburst && !s_ack) ? wmaster : master;
    assign s_do  = di_a[dsel];
    assign s_sel = sel_a[dsel];

    assign write_start = s_ack & s_we;
    assign arb_point   = ~m_stb[master] | s_ack;

    always_comb begin
        m_ack         = '0;
        m_ack[master] = s_ack;
    end

    always_comb begin
        next_master = master;
        found       = 1'b0;
        idx         = 0;
        if (arb_point) begin
            if ((prio0 != 0) && m_stb[0]) begin
                next_master = '0;
            end else begin
                for (int k = 1; k < nm; k++) begin
                    idx = (int'(master) + k) % nm;
                    if (!found && m_stb[idx] && !((prio0 != 0) && (idx == 0))) begin
                        next_master = mw'(idx);
                        found       = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            master  <= '0;
            wmaster <= '0;
            cnt     <= '0;
        end else begin
            master <= next_master;
            if (write_start) begin
                cnt     <= bw'(burst_len - 1);
                wmaster <= master;
            end else begin
                if (cnt != '0)
                    cnt <= cnt - 1'b1;
                else
                    wmaster <= next_master;
            end
        end
    end

endmodule
